// File: rtl/tawas_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tawas_pkg : shared widths, register map and FSM states for Tawas     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tawas_pkg;

    localparam int TAWAS_PC_W    = 24;
    localparam int TAWAS_THREADS = 4;

    localparam logic [3:0] TC_RUN        = 4'h0;
    localparam logic [3:0] TC_STATUS     = 4'h1;
    localparam logic [3:0] TC_RESTART    = 4'h2;
    localparam logic [3:0] TC_START_PC0  = 4'h4;
    localparam logic [3:0] TC_STALL_CNT0 = 4'hC;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } tc_state_t;

endpackage
`default_nettype wire

// File: rtl/tawas_sat_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tawas_sat_cnt : saturating up-counter with synchronous clear         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tawas_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Clear beats a simultaneous increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/tawas_thread_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tawas_thread_ctl : per-thread run mask, restart sequencer, stall cnt |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tawas_thread_ctl
    import tawas_pkg::*;
#(
    parameter logic [3:0]            RESET_RUN = 4'h1,
    parameter logic [TAWAS_PC_W-1:0] RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_slice,
    input  logic [3:0]            i_rcn_stall,
    input  logic                  i_cfg_cs,
    input  logic                  i_cfg_wr,
    input  logic [3:0]            i_cfg_addr,
    input  logic [31:0]           i_cfg_wdata,
    output logic [31:0]           o_cfg_rdata,
    output logic [3:0]            o_thread_run,
    output logic                  o_restart_vld,
    output logic [1:0]            o_restart_slice,
    output logic [TAWAS_PC_W-1:0] o_restart_pc,
    input  logic                  i_restart_ack
);

    tc_state_t             r_state, w_state_nxt;
    logic [3:0]            r_run, r_pend, w_run_nxt, w_pend_nxt;
    logic [TAWAS_PC_W-1:0] r_start_pc [TAWAS_THREADS];
    logic [1:0]            r_rs_slice;
    logic [TAWAS_PC_W-1:0] r_rs_pc;
    logic [31:0]           r_rdata, w_rdata;
    logic [15:0]           w_stall_cnt [TAWAS_THREADS];
    logic                  w_wr, w_rd, w_issue, w_start, w_done;
    logic [3:0]            w_issue_mask;
    logic                  w_unused;

    assign w_wr         = i_cfg_cs & i_cfg_wr;
    assign w_rd         = i_cfg_cs & ~i_cfg_wr;
    assign w_issue      = (r_state == ISSUE);
    assign w_done       = w_issue & i_restart_ack;
    assign w_issue_mask = w_issue ? (4'b0001 << r_rs_slice) : 4'b0000;
    assign w_start      = ~w_issue & r_pend[i_slice];
    assign w_unused     = ^i_cfg_wdata[31:TAWAS_PC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start)       w_state_nxt = ISSUE;
            ISSUE:   if (i_restart_ack) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The issuing thread's pend bit stays set until ack, so RUN writes
    // cannot cancel it and RESTART writes cannot re-arm it.
    always_comb begin
        w_run_nxt  = r_run;
        w_pend_nxt = r_pend;
        if (w_wr && (i_cfg_addr == TC_RUN)) begin
            w_run_nxt  = i_cfg_wdata[3:0];
            w_pend_nxt = w_pend_nxt & (i_cfg_wdata[3:0] | w_issue_mask);
        end
        if (w_wr && (i_cfg_addr == TC_RESTART))
            w_pend_nxt = w_pend_nxt | (i_cfg_wdata[3:0] & ~w_issue_mask);
        if (w_done) begin
            w_run_nxt  = w_run_nxt | w_issue_mask;
            w_pend_nxt = w_pend_nxt & ~w_issue_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run      <= RESET_RUN;
            r_pend     <= '0;
            r_rs_slice <= '0;
            r_rs_pc    <= '0;
            r_rdata    <= '0;
            for (int n = 0; n < TAWAS_THREADS; n++) r_start_pc[n] <= RESET_PC;
        end else begin
            r_run   <= w_run_nxt;
            r_pend  <= w_pend_nxt;
            r_rdata <= w_rdata;
            if (w_start) begin
                r_rs_slice <= i_slice;
                r_rs_pc    <= r_start_pc[i_slice];
            end
            if (w_wr && (i_cfg_addr[3:2] == TC_START_PC0[3:2]))
                r_start_pc[i_cfg_addr[1:0]] <= i_cfg_wdata[TAWAS_PC_W-1:0];
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            if (i_cfg_addr == TC_RUN)
                w_rdata = {28'b0, r_run};
            else if (i_cfg_addr == TC_STATUS)
                w_rdata = {20'b0, i_rcn_stall, r_pend, r_run};
            else if (i_cfg_addr[3:2] == TC_START_PC0[3:2])
                w_rdata = {{(32-TAWAS_PC_W){1'b0}}, r_start_pc[i_cfg_addr[1:0]]};
            else if (i_cfg_addr[3:2] == TC_STALL_CNT0[3:2])
                w_rdata = {16'b0, w_stall_cnt[i_cfg_addr[1:0]]};
        end
    end

    generate
        for (genvar g = 0; g < TAWAS_THREADS; g++) begin : g_stall_cnt
            tawas_sat_cnt #(.W(16)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .i_inc (i_rcn_stall[g]),
                .i_clr (w_wr && (i_cfg_addr == (TC_STALL_CNT0 | 4'(g)))),
                .o_cnt (w_stall_cnt[g])
            );
        end
    endgenerate

    assign o_cfg_rdata     = r_rdata;
    assign o_thread_run    = r_run & ~r_pend & ~w_issue_mask;
    assign o_restart_vld   = w_issue;
    assign o_restart_slice = r_rs_slice;
    assign o_restart_pc    = r_rs_pc;

endmodule
`default_nettype wire
